// File: rtl/dl_router.sv
// dl_router: filters one ioctl index, decodes address windows and packs download bytes into DW-bit words
// with byte enables, delivered over valid/ready with ioctl_wait back-pressure.
module dl_router #(
   parameter int REGIONS = 4,
   parameter int DW = 16,
   parameter int AW = 25,
   parameter logic [7:0] INDEX = 8'd0,
   parameter logic [REGIONS*AW-1:0] BASES = '0,
   parameter logic [REGIONS*AW-1:0] SIZES = '0,
   parameter bit BIG_ENDIAN = 1'b0,
   localparam int BPW = DW / 8,
   localparam int RW = REGIONS > 1 ? $clog2(REGIONS) : 1
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               ioctl_download,
   input  logic               ioctl_wr,
   input  logic [AW-1:0]      ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   input  logic [7:0]         ioctl_index,
   output logic               ioctl_wait,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RW-1:0]      out_region,
   output logic [AW-1:0]      out_addr,
   output logic [DW-1:0]      out_data,
   output logic [BPW-1:0]     out_be,
   output logic [REGIONS-1:0] region_loaded,
   output logic               dl_done,
   output logic               err_oob
);
   localparam int LW = BPW > 1 ? $clog2(BPW) : 1;
   localparam int LB = $clog2(BPW);

   for (genvar r = 0; r < REGIONS; r++) begin : g_chk
      if ({1'b0, BASES[r*AW +: AW]} + {1'b0, SIZES[r*AW +: AW]} > {1'b1, {AW{1'b0}}}) begin : g_err
         $error("dl_router: region %0d extends past the address space", r);
      end
   end

   logic dl_q, active, ending, pend_v, out_last;
   logic [AW-1:0] pend_addr;
   logic [7:0] pend_dat;
   logic [RW-1:0] acc_region;
   logic [AW-1:0] acc_waddr;
   logic [DW-1:0] acc_data;
   logic [BPW-1:0] acc_be;

   logic start, fall, hs, out_free, pv, byte_v, hit, last, diff, complete, use_b;
   logic park, acc_take, acc_clr, load_old, load_new, flush_c, load, done;
   logic [AW-1:0] b_addr, base, size, la, waddr;
   logic [7:0] b_dat;
   logic [RW-1:0] sel;
   logic [LW-1:0] lane;
   logic [DW-1:0] a_data, m_data;
   logic [BPW-1:0] a_be, m_be;

   assign start = ioctl_download && !dl_q && ioctl_index == INDEX;
   assign fall = !ioctl_download && dl_q && active;
   assign hs = out_valid && out_ready;
   assign out_free = !out_valid || out_ready;
   // a start wipes the accumulator and pending slot before this cycle's byte is merged
   assign a_be = start ? '0 : acc_be;
   assign a_data = start ? '0 : acc_data;
   assign pv = pend_v && !start;
   assign byte_v = pv ? out_free : ioctl_download && ioctl_wr && ioctl_index == INDEX && !ioctl_wait;
   assign b_addr = pv ? pend_addr : ioctl_addr;
   assign b_dat = pv ? pend_dat : ioctl_dout;
   assign ioctl_wait = pend_v;

   always_comb begin
      hit = 1'b0;
      sel = '0;
      base = '0;
      size = '0;
      for (int i = REGIONS - 1; i >= 0; i--)
         if ({1'b0, b_addr} >= {1'b0, BASES[i*AW +: AW]} &&
             {1'b0, b_addr} < {1'b0, BASES[i*AW +: AW]} + {1'b0, SIZES[i*AW +: AW]}) begin
            hit = 1'b1;
            sel = RW'(i);
            base = BASES[i*AW +: AW];
            size = SIZES[i*AW +: AW];
         end
   end

   assign la = b_addr - base;
   assign waddr = la >> LB;
   assign lane = LW'(la & AW'(BPW - 1));
   assign last = la == size - AW'(1);
   assign diff = |a_be && (sel != acc_region || waddr != acc_waddr);
   assign complete = lane == LW'(BPW - 1) || last;
   assign m_be = (diff ? '0 : a_be) | (BPW'(1) << lane);
   assign m_data = (diff ? '0 : a_data) |
                   (DW'(b_dat) << (BIG_ENDIAN ? DW - 8 - 8 * int'(lane) : 8 * int'(lane)));

   // a byte needing a second flush in the same cycle (old word plus its own) waits in the pending slot
   assign use_b = byte_v && hit;
   assign park = use_b && (out_free ? diff && complete : diff || complete);
   assign load_old = use_b && out_free && diff;
   assign load_new = use_b && out_free && !diff && complete;
   assign flush_c = !use_b && !pv && (fall || ending) && |a_be && out_free;
   assign load = load_old || load_new || flush_c;
   assign acc_take = use_b && !complete && (out_free || !diff);
   assign acc_clr = (use_b && out_free && complete) || flush_c;
   assign done = ending && !start && !(|a_be) && !pv && !out_valid;

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         dl_q <= 1'b0;
         active <= 1'b0;
         ending <= 1'b0;
         pend_v <= 1'b0;
         pend_addr <= '0;
         pend_dat <= '0;
         acc_region <= '0;
         acc_waddr <= '0;
         acc_data <= '0;
         acc_be <= '0;
         out_valid <= 1'b0;
         out_region <= '0;
         out_addr <= '0;
         out_data <= '0;
         out_be <= '0;
         out_last <= 1'b0;
         region_loaded <= '0;
         dl_done <= 1'b0;
         err_oob <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         active <= start || (active && !fall);
         ending <= !start && (fall || (ending && !done));
         dl_done <= done;
         err_oob <= (err_oob && !start) || (byte_v && !hit);
         region_loaded <= (start ? '0 : region_loaded) | (hs && out_last ? REGIONS'(1) << out_region : '0);
         pend_v <= park || (pv && !byte_v);
         if (park) begin
            pend_addr <= b_addr;
            pend_dat <= b_dat;
         end
         acc_region <= acc_take ? sel : acc_region;
         acc_waddr <= acc_take ? waddr : acc_waddr;
         acc_data <= acc_take ? m_data : acc_clr ? '0 : a_data;
         acc_be <= acc_take ? m_be : acc_clr ? '0 : a_be;
         out_valid <= load || (out_valid && !out_ready);
         if (load) begin
            out_region <= load_new ? sel : acc_region;
            out_addr <= load_new ? waddr : acc_waddr;
            out_data <= load_new ? m_data : a_data;
            out_be <= load_new ? m_be : a_be;
            out_last <= load_new && last;
         end
      end
endmodule
